// File: rtl/valida_rega_multi.sv
// valida_rega_multi: multi-zone irrigation request validator.
// Each zone runs its own registered state machine. A zone waters for a minimum number of
// cycles once started, only MAX_ATIVAS zones may water at once, and errors are sticky
// until they are cleared.
// Optional feature: define VALIDA_REGA_CONT_ERRO_EN to build the saturating error-entry
// counter on erro_cnt. Without it, erro_cnt is tied to zero.
module valida_rega_multi #(
  parameter int NZ         = 4,
  parameter int MIN_CICLOS = 8,
  parameter int MAX_ATIVAS = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NZ-1:0]   asp,
  input  logic [NZ-1:0]   got,
  input  logic [1:0]      mef1,
  input  logic            limpeza,
  input  logic            VE,
  input  logic            clr_erro,
  output logic [2*NZ-1:0] rega,
  output logic [NZ-1:0]   erro,
  output logic            erro_any,
  output logic [7:0]      erro_cnt
);

  localparam int CW = $clog2(MIN_CICLOS + 1);

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    ASPERSAO = 2'd1,
    GOTEJ    = 2'd2,
    ERRO     = 2'd3
  } zona_t;

  zona_t         estado_q [NZ];
  zona_t         estado_d [NZ];
  logic [CW-1:0] cnt_q    [NZ];
  logic [CW-1:0] cnt_d    [NZ];
  logic [NZ-1:0] req;
  logic [NZ-1:0] err;
  logic [NZ-1:0] erro_d;
  int            ativas;
  int            iniciando;

  assign req = asp | got;
  assign err = ({NZ{limpeza}} & req)
             | ({NZ{mef1 != 2'b11}} & req)
             | (asp & got)
             | ({NZ{VE}} & req);

  // Per-zone next state, run counter and admission; lower zone indices claim free slots first
  always_comb begin
    ativas    = 0;
    iniciando = 0;
    for (int i = 0; i < NZ; i++) begin
      if (estado_q[i] == ASPERSAO || estado_q[i] == GOTEJ) begin
        ativas = ativas + 1;
      end
    end
    for (int i = 0; i < NZ; i++) begin
      estado_d[i] = estado_q[i];
      cnt_d[i]    = cnt_q[i];
      case (estado_q[i])
        OCIOSO: begin
          if (err[i]) begin
            estado_d[i] = ERRO;
          end else if (req[i] && ((ativas + iniciando) < MAX_ATIVAS)) begin
            estado_d[i] = asp[i] ? ASPERSAO : GOTEJ;
            cnt_d[i]    = '0;
            iniciando   = iniciando + 1;
          end
        end
        ASPERSAO, GOTEJ: begin
          // the counter holds completed cycles, so the cycle now ending makes it cnt_q+1
          if (err[i]) begin
            estado_d[i] = ERRO;
          end else if ((cnt_q[i] >= CW'(MIN_CICLOS - 1)) &&
                       !((estado_q[i] == ASPERSAO) ? asp[i] : got[i])) begin
            estado_d[i] = OCIOSO;
          end else if (cnt_q[i] < CW'(MIN_CICLOS)) begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        ERRO: begin
          if (clr_erro && !req[i] && !err[i]) begin
            estado_d[i] = OCIOSO;
          end
        end
        default: estado_d[i] = OCIOSO;
      endcase
      erro_d[i] = (estado_d[i] == ERRO);
    end
  end

  // State, counters and all outputs are registered from the next-state values
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NZ; i++) begin
        estado_q[i] <= OCIOSO;
        cnt_q[i]    <= '0;
      end
      rega     <= '0;
      erro     <= '0;
      erro_any <= 1'b0;
    end else begin
      for (int i = 0; i < NZ; i++) begin
        estado_q[i]   <= estado_d[i];
        cnt_q[i]      <= cnt_d[i];
        rega[2*i+1]   <= (estado_d[i] == ASPERSAO);
        rega[2*i]     <= (estado_d[i] == GOTEJ);
      end
      erro     <= erro_d;
      erro_any <= |erro_d;
    end
  end

`ifdef VALIDA_REGA_CONT_ERRO_EN
  int         entradas;
  logic [8:0] soma;

  // Count zones that enter ERRO this cycle and add them to the saturating total
  always_comb begin
    entradas = 0;
    for (int i = 0; i < NZ; i++) begin
      if (erro_d[i] && (estado_q[i] != ERRO)) begin
        entradas = entradas + 1;
      end
    end
    soma = {1'b0, erro_cnt} + 9'(entradas);
  end

  // Error-entry counter saturates at 255 and clears only on reset
  always_ff @(posedge clk) begin
    if (reset) begin
      erro_cnt <= 8'd0;
    end else begin
      erro_cnt <= soma[8] ? 8'd255 : soma[7:0];
    end
  end
`else
  assign erro_cnt = 8'd0;
`endif

endmodule
